// File: rtl/rotate_arbiter_pkg.sv
// rotate_arbiter_pkg: shared state encodings and direction/port constants
package rotate_arbiter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;
  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;
  localparam logic PORT0     = 1'b0;
  localparam logic PORT1     = 1'b1;
endpackage

// File: rtl/rotate_arbiter_rotate_unit.sv
// rotate_unit: combinational 8-bit barrel rotator, left or right by 0..7
module rotate_unit
  import rotate_arbiter_pkg::*;
(
  input  logic [7:0] a,
  input  logic [2:0] amt,
  input  logic       dir,
  output logic [7:0] y
);
  logic [15:0] sh;
  always_comb begin
    sh = 16'h0;
    case (dir)
      DIR_RIGHT: sh = {a, a} >> amt;
      DIR_LEFT:  sh = ({a, a} << amt) >> 8;
    endcase
    y = sh[7:0];
  end
endmodule

// File: rtl/rotate_arbiter.sv
// rotate_arbiter: two-port arbiter sharing one registered 8-bit rotator
module rotate_arbiter
  import rotate_arbiter_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic [7:0] a0,
  input  logic [2:0] amt0,
  input  logic       dir0,
  output logic       ack0,
  input  logic       req1,
  input  logic [7:0] a1,
  input  logic [2:0] amt1,
  input  logic       dir1,
  output logic       ack1,
  output logic [7:0] y,
  output logic       done_tick,
  output logic       done_id,
  output logic       busy
);
  state_t     state_q, state_d;
  logic       ptr_q, ptr_d;
  logic [7:0] a_q, a_d;
  logic [2:0] amt_q, amt_d;
  logic       dir_q, dir_d;
  logic       id_q, id_d;
  logic [7:0] y_q, y_d;
  logic       done_id_q, done_id_d;
  logic       done_q, done_d;
  logic       ack0_q, ack0_d;
  logic       ack1_q, ack1_d;
  logic       win;
  logic [7:0] rot;
  rotate_unit u_rot (.a(a_q), .amt(amt_q), .dir(dir_q), .y(rot));
  assign win = RR_EN ? ((req0 && req1) ? ptr_q : req1) : !req0;
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    a_d       = a_q;
    amt_d     = amt_q;
    dir_d     = dir_q;
    id_d      = id_q;
    y_d       = y_q;
    done_id_d = done_id_q;
    done_d    = 1'b0;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    case (state_q)
      IDLE: if (req0 || req1) begin
        state_d = CALC;
        id_d    = win;
        a_d     = win ? a1 : a0;
        amt_d   = win ? amt1 : amt0;
        dir_d   = win ? dir1 : dir0;
      end
      CALC: begin
        state_d   = DONE;
        y_d       = rot;
        done_id_d = id_q;
        done_d    = 1'b1;
        ack0_d    = id_q == PORT0;
        ack1_d    = id_q == PORT1;
      end
      DONE: begin
        state_d = IDLE;
        ptr_d   = RR_EN ? !id_q : ptr_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= PORT0;
      a_q       <= '0;
      amt_q     <= '0;
      dir_q     <= 1'b0;
      id_q      <= 1'b0;
      y_q       <= '0;
      done_id_q <= 1'b0;
      done_q    <= 1'b0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      a_q       <= a_d;
      amt_q     <= amt_d;
      dir_q     <= dir_d;
      id_q      <= id_d;
      y_q       <= y_d;
      done_id_q <= done_id_d;
      done_q    <= done_d;
      ack0_q    <= ack0_d;
      ack1_q    <= ack1_d;
    end
  end
  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign y         = y_q;
  assign done_tick = done_q;
  assign done_id   = done_id_q;
  assign busy      = state_q != IDLE;
endmodule

// File: tb/tb_rotate_arbiter.sv
// tb_rotate_arbiter: directed checks of round-robin and fixed-priority rotate arbiters
module tb_rotate_arbiter;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] a0 = '0, a1 = '0;
  logic [2:0] amt0 = '0, amt1 = '0;
  logic       dir0 = 1'b0, dir1 = 1'b0;
  logic       ack0, ack1, done_tick, done_id, busy;
  logic [7:0] y;
  logic       f_ack0, f_ack1, f_done_tick, f_done_id, f_busy;
  logic [7:0] f_y;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  rotate_arbiter #(.RR_EN(1'b1)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .a0(a0), .amt0(amt0), .dir0(dir0), .ack0(ack0),
    .req1(req1), .a1(a1), .amt1(amt1), .dir1(dir1), .ack1(ack1),
    .y(y), .done_tick(done_tick), .done_id(done_id), .busy(busy)
  );
  rotate_arbiter #(.RR_EN(1'b0)) dut_fp (
    .clk(clk), .reset(reset),
    .req0(req0), .a0(a0), .amt0(amt0), .dir0(dir0), .ack0(f_ack0),
    .req1(req1), .a1(a1), .amt1(amt1), .dir1(dir1), .ack1(f_ack1),
    .y(f_y), .done_tick(f_done_tick), .done_id(f_done_id), .busy(f_busy)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask
  task automatic run_op(input logic port, input logic [7:0] a, input logic [2:0] amt,
                        input logic dir, input logic [7:0] exp_y);
    if (port) begin a1 = a; amt1 = amt; dir1 = dir; req1 = 1'b1; end
    else begin a0 = a; amt0 = amt; dir0 = dir; req0 = 1'b1; end
    step();
    chk("calc_busy", busy, 1);
    chk("calc_no_done", done_tick, 0);
    step();
    chk("y", y, exp_y);
    chk("fp_y", f_y, exp_y);
    chk("done_id", done_id, port);
    chk("done_tick", done_tick, 1);
    chk("ack0", ack0, !port);
    chk("ack1", ack1, port);
    chk("done_busy", busy, 1);
    req0 = 1'b0;
    req1 = 1'b0;
    step();
    chk("ack_clear", {ack0, ack1, done_tick}, 0);
    chk("idle_busy", busy, 0);
    chk("y_held", y, exp_y);
  endtask
  initial begin
    step();
    step();
    chk("rst_y", y, 0);
    chk("rst_flags", {ack0, ack1, done_tick, done_id, busy}, 0);
    reset = 1'b0;
    step();
    chk("idle_no_req", busy, 0);
    run_op(1'b0, 8'h96, 3'd3, 1'b0, 8'hD2);
    run_op(1'b1, 8'h96, 3'd3, 1'b1, 8'hB4);
    run_op(1'b0, 8'h5A, 3'd0, 1'b0, 8'h5A);
    run_op(1'b1, 8'h5A, 3'd0, 1'b1, 8'h5A);
    run_op(1'b1, 8'h01, 3'd7, 1'b1, 8'h80);
    run_op(1'b0, 8'h01, 3'd1, 1'b0, 8'h80);
    run_op(1'b0, 8'h80, 3'd7, 1'b0, 8'h01);
    do_reset();
    a0 = 8'h96; amt0 = 3'd3; dir0 = 1'b0;
    a1 = 8'h96; amt1 = 3'd3; dir1 = 1'b1;
    req0 = 1'b1; req1 = 1'b1;
    step();
    step();
    chk("both_ack0", {ack0, ack1}, 2'b10);
    chk("both_y0", y, 8'hD2);
    req0 = 1'b0;
    step();
    step();
    chk("both_mid", {ack0, ack1, busy}, 3'b001);
    step();
    chk("both_ack1", {ack0, ack1}, 2'b01);
    chk("both_y1", y, 8'hB4);
    chk("both_id1", done_id, 1);
    chk("fp_both_ack1", {f_ack0, f_ack1}, 2'b01);
    req1 = 1'b0;
    step();
    reset = 1'b1;
    req0 = 1'b1; req1 = 1'b1;
    step();
    chk("rst_with_req", {ack0, busy, f_ack0, f_busy}, 0);
    reset = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      chk("rr_ack0", ack0, (k % 3 == 2) && (((k - 2) / 3) % 2 == 0));
      chk("rr_ack1", ack1, (k % 3 == 2) && (((k - 2) / 3) % 2 == 1));
      chk("fp_ack0", f_ack0, k % 3 == 2);
      chk("fp_ack1", f_ack1, 0);
    end
    req0 = 1'b0; req1 = 1'b0;
    do_reset();
    a0 = 8'h96; amt0 = 3'd3; dir0 = 1'b0; req0 = 1'b1;
    step();
    a0 = 8'hFF; amt0 = 3'd5; dir0 = 1'b1;
    step();
    chk("sampled_y", y, 8'hD2);
    chk("sampled_ack0", ack0, 1);
    req0 = 1'b0;
    step();
    a0 = 8'h0F; amt0 = 3'd1; dir0 = 1'b0; req0 = 1'b1;
    step();
    chk("abort_calc", busy, 1);
    reset = 1'b1;
    req0 = 1'b0;
    step();
    chk("abort_y", y, 0);
    chk("abort_flags", {ack0, done_tick, busy}, 0);
    reset = 1'b0;
    step();
    step();
    chk("abort_quiet", {ack0, ack1, done_tick, busy}, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
